// File: rtl/lstm_pkg.sv
// lstm_pkg: fixed-point constants plus saturation and hard-activation helpers
// shared by the streaming LSTM cell.
package lstm_pkg;
   localparam int Q_FRAC = 8;
   localparam int ONE = 1 << Q_FRAC;
   localparam int HALF = 1 << (Q_FRAC - 1);
   typedef logic signed [47:0] wide_t;

   function automatic wide_t sat(input wide_t x, input int dw);
      wide_t hi, lo;
      hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (dw - 1));
      return (x > hi) ? hi : (x < lo) ? lo : x;
   endfunction

   function automatic wide_t htanh(input wide_t x, input int fb);
      wide_t one;
      one = wide_t'(1) <<< fb;
      return (x > one) ? one : (x < -one) ? -one : x;
   endfunction

   function automatic wide_t hsig(input wide_t x, input int fb);
      wide_t one, y;
      one = wide_t'(1) <<< fb;
      y = (x >>> 2) + (one >>> 1);
      return (y > one) ? one : (y < wide_t'(0)) ? wide_t'(0) : y;
   endfunction
endpackage

// File: rtl/lstm_act.sv
// lstm_act: combinational hard-sigmoid (SIG=1) or hard-tanh (SIG=0) on one gate.
module lstm_act
   import lstm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS = 8,
   parameter bit SIG = 1'b1
)(
   input  logic [DATA_WIDTH-1:0] z,
   output logic [DATA_WIDTH-1:0] a
);
   wide_t x;
   always_comb begin
      x = wide_t'($signed(z));
      a = DATA_WIDTH'(SIG ? hsig(x, FRAC_BITS) : htanh(x, FRAC_BITS));
   end
endmodule

// File: rtl/lstm_cell_stream.sv
// lstm_cell_stream: 3-stage streaming fixed-point LSTM cell; one hidden element
// per beat, cell state kept per element across timesteps.
module lstm_cell_stream
   import lstm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS = 8,
   parameter int HIDDEN_SIZE = 16,
   parameter int IDX_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_zi,
   input  logic [DATA_WIDTH-1:0] in_zf,
   input  logic [DATA_WIDTH-1:0] in_zg,
   input  logic [DATA_WIDTH-1:0] in_zo,
   input  logic                  in_seq_start,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_h,
   output logic [DATA_WIDTH-1:0] out_c,
   output logic [IDX_W-1:0]      out_idx,
   output logic                  out_last
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_SIZE - 1);

   logic en, accept, wr, seq_flag, seq_cur;
   logic [IDX_W-1:0] idx, s1_idx, s2_idx;
   logic [DATA_WIDTH-1:0] act_i, act_f, act_g, act_o;
   logic s1_valid, s1_last, s2_valid, s2_last;
   logic signed [DATA_WIDTH-1:0] s1_i, s1_f, s1_g, s1_o, s1_cp, s2_o, s2_c;
   logic signed [DATA_WIDTH-1:0] c_prev, c_new, h_new;
   logic signed [DATA_WIDTH-1:0] mem [HIDDEN_SIZE];

   assign en = !(out_valid && !out_ready);
   assign in_ready = en;
   assign accept = in_valid && en;
   assign wr = en && s1_valid;
   // the seq flag for the beat at index 0 comes straight from the input
   assign seq_cur = (idx == '0) ? in_seq_start : seq_flag;

   lstm_act #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .SIG(1'b1)) u_i (.z(in_zi), .a(act_i));
   lstm_act #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .SIG(1'b1)) u_f (.z(in_zf), .a(act_f));
   lstm_act #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .SIG(1'b0)) u_g (.z(in_zg), .a(act_g));
   lstm_act #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .SIG(1'b1)) u_o (.z(in_zo), .a(act_o));

   always_comb begin
      c_new = DATA_WIDTH'(sat(((wide_t'(s1_f) * wide_t'(s1_cp)) >>> FRAC_BITS)
                            + ((wide_t'(s1_i) * wide_t'(s1_g)) >>> FRAC_BITS), DATA_WIDTH));
      h_new = DATA_WIDTH'(sat((wide_t'(s2_o) * htanh(wide_t'(s2_c), FRAC_BITS)) >>> FRAC_BITS, DATA_WIDTH));
      // bypass the memory when the element is being written back this very cycle
      c_prev = seq_cur ? '0 : (wr && s1_idx == idx) ? c_new : mem[idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         seq_flag <= 1'b0;
         s1_valid <= 1'b0;
         s1_idx <= '0;
         s1_last <= 1'b0;
         s1_i <= '0;
         s1_f <= '0;
         s1_g <= '0;
         s1_o <= '0;
         s1_cp <= '0;
         s2_valid <= 1'b0;
         s2_idx <= '0;
         s2_last <= 1'b0;
         s2_o <= '0;
         s2_c <= '0;
         out_valid <= 1'b0;
         out_idx <= '0;
         out_last <= 1'b0;
         out_h <= '0;
         out_c <= '0;
      end else if (en) begin
         if (accept) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (idx == '0) seq_flag <= in_seq_start;
         end
         s1_valid <= in_valid;
         s1_idx <= idx;
         s1_last <= idx == LAST_IDX;
         s1_i <= act_i;
         s1_f <= act_f;
         s1_g <= act_g;
         s1_o <= act_o;
         s1_cp <= c_prev;
         s2_valid <= s1_valid;
         s2_idx <= s1_idx;
         s2_last <= s1_last;
         s2_o <= s1_o;
         s2_c <= c_new;
         out_valid <= s2_valid;
         out_idx <= s2_idx;
         out_last <= s2_last && s2_valid;
         out_h <= h_new;
         out_c <= s2_c;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[s1_idx] <= c_new;
   end
endmodule

// File: tb/tb_lstm_cell_stream.sv
// tb_lstm_cell_stream: directed vectors for the streaming LSTM cell, using a
// HIDDEN_SIZE=4 instance and a HIDDEN_SIZE=1 instance for write-back bypass.
module tb_lstm_cell_stream;
   import lstm_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic in_valid, in_ready, seq, out_valid, out_ready, out_last;
   logic [15:0] zi, zf, zg, zo, out_h, out_c;
   logic [1:0] out_idx;

   logic b_in_valid, b_in_ready, b_seq, b_out_valid, b_out_ready, b_out_last;
   logic [15:0] b_zi, b_zf, b_zg, b_zo, b_out_h, b_out_c;
   logic [0:0] b_out_idx;

   lstm_cell_stream #(.DATA_WIDTH(16), .FRAC_BITS(8), .HIDDEN_SIZE(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_zi(zi), .in_zf(zf), .in_zg(zg), .in_zo(zo), .in_seq_start(seq),
      .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h), .out_c(out_c),
      .out_idx(out_idx), .out_last(out_last));

   lstm_cell_stream #(.DATA_WIDTH(16), .FRAC_BITS(8), .HIDDEN_SIZE(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_zi(b_zi), .in_zf(b_zf), .in_zg(b_zg), .in_zo(b_zo), .in_seq_start(b_seq),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_h(b_out_h), .out_c(b_out_c),
      .out_idx(b_out_idx), .out_last(b_out_last));

   typedef struct {
      logic seq;
      logic [15:0] zi, zf, zg, zo, c, h;
      int idx;
      logic last;
   } vec_t;

   vec_t tbl [20];
   int n_chk = 0, n_fail = 0;
   logic [15:0] rc, rh;
   int rid, rlat, sent, got, spurious, exp_c;
   logic rl, stall_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic beat4(input logic s, input logic [15:0] a, b, g, o,
                        output logic [15:0] c, h, output int id, output logic l, output int lat);
      in_valid = 1'b1; seq = s; zi = a; zf = b; zg = g; zo = o;
      @(posedge clk); #1;
      in_valid = 1'b0; seq = 1'b0;
      lat = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      c = out_c; h = out_h; id = int'(out_idx); l = out_last;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 16'h0400, 16'hFC00, 16'h0100, 16'h0400, 16'h0100, 16'h0100, 0, 1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3, 1'b1};
      tbl[4]  = '{1'b0, 16'h0400, 16'h0400, 16'h0100, 16'h0400, 16'h0200, 16'h0100, 0, 1'b0};
      tbl[5]  = '{1'b1, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0080, 16'h0040, 1, 1'b0};
      tbl[6]  = '{1'b0, 16'h0400, 16'h0000, 16'hFC00, 16'h0400, 16'hFF00, 16'hFF00, 2, 1'b0};
      tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3, 1'b1};
      tbl[8]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0};
      tbl[10] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 1'b0};
      tbl[11] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3, 1'b1};
      tbl[12] = '{1'b0, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0080, 16'h0040, 0, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0};
      tbl[14] = '{1'b0, 16'h0400, 16'h0000, 16'hFF80, 16'h0000, 16'hFF80, 16'hFFC0, 2, 1'b0};
      tbl[15] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3, 1'b1};
      tbl[16] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0020, 0, 1'b0};
      tbl[17] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0};
      tbl[18] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFC0, 16'hFFE0, 2, 1'b0};
      tbl[19] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 3, 1'b1};

      rst = 1'b1;
      in_valid = 1'b0; seq = 1'b0; zi = '0; zf = '0; zg = '0; zo = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_seq = 1'b0; b_zi = '0; b_zf = '0; b_zg = '0; b_zo = '0; b_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_h", out_h, 0);
      chk("reset out_c", out_c, 0);
      chk("reset out_idx", out_idx, 0);
      chk("reset out_last", out_last, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset b_out_valid", b_out_valid, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) begin
         beat4(tbl[i].seq, tbl[i].zi, tbl[i].zf, tbl[i].zg, tbl[i].zo, rc, rh, rid, rl, rlat);
         chk($sformatf("v%0d latency", i), rlat, 2);
         chk($sformatf("v%0d out_c", i), rc, tbl[i].c);
         chk($sformatf("v%0d out_h", i), rh, tbl[i].h);
         chk($sformatf("v%0d out_idx", i), rid, tbl[i].idx);
         chk($sformatf("v%0d out_last", i), rl, tbl[i].last);
      end

      exp_c = 0;
      for (int t = 0; t < 200; t++) begin
         for (int e = 0; e < 4; e++) begin
            if (e == 0) begin
               beat4(t == 0, 16'h0400, 16'h0400, 16'h0400, 16'h0400, rc, rh, rid, rl, rlat);
               exp_c = (t == 0) ? ONE : ((exp_c + ONE > 32767) ? 32767 : exp_c + ONE);
               chk($sformatf("sat t%0d out_c", t), rc, exp_c);
               chk($sformatf("sat t%0d out_h", t), rh, ONE);
            end else begin
               beat4(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, rc, rh, rid, rl, rlat);
            end
         end
      end

      sent = 0; got = 0; stall_seen = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 9);
         in_valid = sent < 8; seq = sent == 0;
         zi = 16'h0400; zf = 16'hFC00; zo = 16'h0400; zg = 16'((sent + 1) * 16);
         @(negedge clk);
         if (!in_ready) stall_seen = 1'b1;
         if (out_valid && out_ready) begin
            chk($sformatf("bp beat%0d out_c", got), out_c, (got + 1) * 16);
            chk($sformatf("bp beat%0d out_h", got), out_h, (got + 1) * 16);
            chk($sformatf("bp beat%0d out_idx", got), out_idx, got % 4);
            chk($sformatf("bp beat%0d out_last", got), out_last, (got % 4) == 3);
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; seq = 1'b0; out_ready = 1'b1;
      chk("bp beats out", got, 8);
      chk("bp beats in", sent, 8);
      chk("bp in_ready dropped", stall_seen, 1);

      sent = 0; got = 0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
         b_in_valid = sent < 3; b_seq = sent == 0;
         b_zi = 16'h0400; b_zf = 16'h0400; b_zg = 16'h0100; b_zo = 16'h0400;
         @(negedge clk);
         if (b_out_valid) begin
            chk($sformatf("fwd beat%0d out_c", got), b_out_c, (got + 1) * ONE);
            chk($sformatf("fwd beat%0d out_h", got), b_out_h, ONE);
            chk($sformatf("fwd beat%0d out_idx", got), b_out_idx, 0);
            chk($sformatf("fwd beat%0d out_last", got), b_out_last, 1);
            got++;
         end
         if (b_in_valid && b_in_ready) sent++;
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0; b_seq = 1'b0;
      chk("fwd beats out", got, 3);

      in_valid = 1'b1; seq = 1'b1; zi = 16'h0400; zf = 16'hFC00; zg = 16'h0100; zo = 16'h0400;
      @(posedge clk); #1;
      seq = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async reset out_valid", out_valid, 0);
      chk("async reset out_c", out_c, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      spurious = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) spurious++;
      end
      chk("post-reset no output", spurious, 0);
      @(posedge clk); #1;
      beat4(1'b1, 16'h0400, 16'h0400, 16'h0100, 16'h0400, rc, rh, rid, rl, rlat);
      chk("post-reset latency", rlat, 2);
      chk("post-reset out_idx", rid, 0);
      chk("post-reset out_c", rc, ONE);
      chk("post-reset out_h", rh, ONE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
